// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-memory port bundle for mem_access_unit.
// The slave modport is the unit itself; the master modport is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Pipeline request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Completion channel (no backpressure)
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // Word-addressed data-memory port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_writeEnable;
  logic [DATA_W-1:0] mem_dataWrite;
  logic [DATA_W-1:0] mem_dataOutput;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_dataOutput,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_writeEnable, mem_dataWrite
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_dataOutput,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_writeEnable, mem_dataWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory.
// Handles byte/halfword/word accesses, sign/zero extension on loads, a two-cycle
// read-modify-write for sub-word stores, and rejects misaligned/out-of-range
// requests without touching memory. One request is outstanding at a time.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(MEM_DEPTH);

  // Illegal size, misalignment, or word index beyond the attached memory.
  function automatic logic req_is_err(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] idx;
    logic              bad;
    idx = {2'b00, addr[ADDR_W-1:2]};
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    req_is_err = bad | (idx >= DEPTH_C);
  endfunction

  // Pick the addressed little-endian lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace the addressed lane of the current memory word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{lane, 3'b000} +: 8]    = wdata[7:0];
      SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    store_merge = res;
  endfunction

  state_e            state_q, state_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_dataWrite_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept_s;
  logic              req_err_s;
  logic              subword_store_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] merged_s;

  assign accept_s        = (state_q == IDLE) & bus.req_valid;
  assign req_err_s       = req_is_err(bus.req_size, bus.req_addr);
  assign subword_store_s = write_q & (size_q != SZ_WORD);
  assign load_data_s     = load_extract(bus.mem_dataOutput, size_q, lane_q, signed_q);
  assign merged_s        = store_merge(bus.mem_dataOutput, size_q, lane_q, wdata_q);

  // Next-state decode: errors skip straight to RESP, sub-word stores detour through MERGE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err_s) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (subword_store_s) begin
          state_d = MERGE;
        end else begin
          state_d = RESP;
        end
      end
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe decoded from the state register so reset kills it in the same cycle.
  always_comb begin
    mem_we_s = 1'b0;
    case (state_q)
      ACCESS:  mem_we_s = write_q & (size_q == SZ_WORD);
      MERGE:   mem_we_s = 1'b1;
      default: mem_we_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture request attributes on accept; they stay stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
      wdata_q  <= '0;
    end else if (accept_s) begin
      write_q  <= bus.req_write;
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      lane_q   <= bus.req_addr[1:0];
      wdata_q  <= bus.req_wdata;
    end
  end

  // Memory address and write data: word stores load data at accept, sub-word stores at ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address_q   <= '0;
      mem_dataWrite_q <= '0;
    end else if (accept_s && !req_err_s) begin
      mem_address_q <= {2'b00, bus.req_addr[ADDR_W-1:2]};
      if (bus.req_write && (bus.req_size == SZ_WORD)) begin
        mem_dataWrite_q <= bus.req_wdata;
      end
    end else if ((state_q == ACCESS) && subword_store_s) begin
      mem_dataWrite_q <= merged_s;
    end
  end

  // Response registers: pulse valid in RESP, update err/rdata only on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= (state_d == RESP);
      if (state_d == RESP) begin
        case (state_q)
          IDLE: begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
          ACCESS: begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? '0 : load_data_s;
          end
          default: begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_writeEnable = mem_we_s;
  assign bus.mem_dataWrite   = mem_dataWrite_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner-case
// sequences (back-to-back, reset during MERGE) and randomized traffic against
// an arithmetic reference model. Edge 0 is the edge before the accept cycle.
module tb_mem_access_unit;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: combinational read, synchronous write, plus a preload port.
  logic [31:0] mem     [0:MEM_DEPTH-1];
  logic [31:0] ref_mem [0:MEM_DEPTH-1];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.mem_writeEnable && bus.mem_address < 32'd1024) mem[bus.mem_address[9:0]] <= bus.mem_dataWrite;
  end
  assign bus.mem_dataOutput = (bus.mem_address < 32'd1024) ? mem[bus.mem_address[9:0]] : 32'h0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = idx[9:0];
    pre_val = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Issue one request from an idle unit; report response, latency and write strobes.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic g_err, output logic [31:0] g_rd,
                         output int lat, output int nwr, output int wedge);
    int  e;
    bit  done;
    lat = -1; nwr = 0; wedge = -1; g_err = 1'b0; g_rd = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    e = 1;
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_signed = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (bus.mem_writeEnable) begin
        nwr++;
        wedge = e + 1;
      end
      if (bus.resp_valid) begin
        done  = 1'b1;
        lat   = e;
        g_err = bus.resp_err;
        g_rd  = bus.resp_rdata;
      end else begin
        @(posedge clk);
        e++;
      end
    end
  endtask

  // Reference behaviour from the access rules, using plain arithmetic on the old word.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old,
                                output logic err, output logic [31:0] rd,
                                output logic [31:0] nw, output int lat);
    int          sh;
    logic [31:0] mask;
    logic [31:0] v;
    err = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0) ||
          (a / 4 >= 32'd1024);
    sh   = 8 * int'(a % 4);
    mask = (sz == 2'b00) ? 32'h000000FF : (sz == 2'b01) ? 32'h0000FFFF : 32'hFFFFFFFF;
    mask = mask << sh;
    rd = 32'h0;
    nw = old;
    if (err) begin
      lat = 1;
    end else if (!w) begin
      v = (old & mask) >> sh;
      if (sg && sz == 2'b00 && v >= 32'd128)   v = v + 32'hFFFFFF00;
      if (sg && sz == 2'b01 && v >= 32'd32768) v = v + 32'hFFFF0000;
      rd  = v;
      lat = 2;
    end else begin
      nw  = (old & ~mask) | ((wd << sh) & mask);
      lat = (sz == 2'b10) ? 2 : 3;
    end
  endfunction

  typedef struct {
    logic        pre_en;
    int          pre_idx;
    logic [31:0] pre_val;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_nwr;
    int          e_wedge;
    int          chk_idx;
    logic [31:0] e_word;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic        g_err, m_err;
    logic [31:0] g_rd, m_rd, m_nw, old, a, wd;
    logic        w, sg;
    logic [1:0]  sz;
    int          lat, nwr, wedge, m_lat, cnt, idx;

    vt[0]  = '{1'b1, 8, 32'h8C0A0020, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8C0A0020, 2, 0, -1, 8, 32'h8C0A0020};
    vt[1]  = '{1'b1, 8, 32'h00F08000, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'hFFFFFF80, 2, 0, -1, 8, 32'h00F08000};
    vt[2]  = '{1'b0, 0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, 32'h00000080, 2, 0, -1, 8, 32'h00F08000};
    vt[3]  = '{1'b0, 0, 32'h0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h000000F0, 2, 0, -1, 8, 32'h00F08000};
    vt[4]  = '{1'b1, 3, 32'h11223344, 1'b1, 2'b00, 1'b0, 32'h0E, 32'h000000AB, 1'b0, 32'h0, 3, 1, 3, 3, 32'h11AB3344};
    vt[5]  = '{1'b0, 0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h11AB3344, 2, 0, -1, 3, 32'h11AB3344};
    vt[6]  = '{1'b1, 0, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, 32'h02, 32'h12345678, 1'b1, 32'h0, 1, 0, -1, 0, 32'hCAFEF00D};
    vt[7]  = '{1'b0, 0, 32'h0, 1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1'b1, 32'h0, 1, 0, -1, 0, 32'hCAFEF00D};
    vt[8]  = '{1'b1, 4, 32'h0BADC0DE, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, -1, 4, 32'h0BADC0DE};
    vt[9]  = '{1'b0, 0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1, 0, -1, 4, 32'h0BADC0DE};
    vt[10] = '{1'b1, 1, 32'h01234567, 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000BEEF, 1'b0, 32'h0, 3, 1, 3, 1, 32'hBEEF4567};
    vt[11] = '{1'b0, 0, 32'h0, 1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 0, -1, 1, 32'hBEEF4567};
    vt[12] = '{1'b0, 0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 1'b0, 32'h000000BE, 2, 0, -1, 1, 32'hBEEF4567};
    vt[13] = '{1'b0, 0, 32'h0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1, 2, 4, 32'hDEADBEEF};
    vt[14] = '{1'b0, 0, 32'h0, 1'b1, 2'b00, 1'b0, 32'h1003, 32'h00000055, 1'b1, 32'h0, 1, 0, -1, 4, 32'hDEADBEEF};

    rst = 1'b1;
    pre_we = 1'b0; pre_idx = 10'd0; pre_val = 32'h0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check32("rst_ready",      {31'b0, bus.req_ready},       32'h1);
    check32("rst_resp_valid", {31'b0, bus.resp_valid},      32'h0);
    check32("rst_resp_err",   {31'b0, bus.resp_err},        32'h0);
    check32("rst_resp_rdata", bus.resp_rdata,               32'h0);
    check32("rst_mem_addr",   bus.mem_address,              32'h0);
    check32("rst_mem_wdata",  bus.mem_dataWrite,            32'h0);
    check32("rst_mem_we",     {31'b0, bus.mem_writeEnable}, 32'h0);

    for (int i = 0; i < 32; i++) preload(i, $urandom);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      if (vt[i].pre_en) preload(vt[i].pre_idx, vt[i].pre_val);
      run_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, g_err, g_rd, lat, nwr, wedge);
      check32($sformatf("vec%0d_err", i),   {31'b0, g_err},   {31'b0, vt[i].e_err});
      check32($sformatf("vec%0d_rdata", i), g_rd,             vt[i].e_rd);
      check32($sformatf("vec%0d_lat", i),   32'(lat),         32'(vt[i].e_lat));
      check32($sformatf("vec%0d_nwr", i),   32'(nwr),         32'(vt[i].e_nwr));
      if (vt[i].e_nwr > 0) check32($sformatf("vec%0d_wedge", i), 32'(wedge), 32'(vt[i].e_wedge));
      check32($sformatf("vec%0d_mem", i),   mem[vt[i].chk_idx], vt[i].e_word);
      if (vt[i].w && !vt[i].e_err) ref_mem[vt[i].chk_idx] = vt[i].e_word;
    end

    // Back-to-back: word store then load issued in the cycle after RESP
    preload(4, 32'h01010101);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
      cnt++;
    end
    check32("b2b_store_busy", 32'(cnt), 32'd2);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cnt = 0;
    g_rd = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) g_rd = bus.resp_rdata;
      if (bus.req_ready) break;
      cnt++;
    end
    check32("b2b_load_busy",  32'(cnt), 32'd2);
    check32("b2b_load_rdata", g_rd,     32'hDEADBEEF);
    ref_mem[4] = 32'hDEADBEEF;

    // Reset asserted during MERGE of a sub-word store
    preload(5, 32'h55667788);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h00000099;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 check32("rmw_merge_we", {31'b0, bus.mem_writeEnable}, 32'h1);
    #1 rst = 1'b1;
    #1 check32("rst_mid_we_drop", {31'b0, bus.mem_writeEnable}, 32'h0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_writeEnable) cnt++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_writeEnable) cnt++;
    end
    check32("rst_mid_no_resp",  32'(cnt), 32'd0);
    check32("rst_mid_ready",    {31'b0, bus.req_ready}, 32'h1);
    check32("rst_mid_mem",      mem[5], 32'h55667788);
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, g_err, g_rd, lat, nwr, wedge);
    check32("rst_mid_reload",   g_rd, 32'h55667788);

    // Randomized traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      wd = $urandom;
      idx = int'(a / 4);
      old = (a / 4 < 32'd1024) ? ref_mem[idx] : 32'h0;
      model(w, sz, sg, a, wd, old, m_err, m_rd, m_nw, m_lat);
      run_req(w, sz, sg, a, wd, g_err, g_rd, lat, nwr, wedge);
      check32($sformatf("rnd%0d_err", i),   {31'b0, g_err}, {31'b0, m_err});
      check32($sformatf("rnd%0d_rdata", i), g_rd,           m_rd);
      check32($sformatf("rnd%0d_lat", i),   32'(lat),       32'(m_lat));
      check32($sformatf("rnd%0d_nwr", i),   32'(nwr),       (!m_err && w) ? 32'd1 : 32'd0);
      if (a / 4 < 32'd1024) begin
        ref_mem[idx] = m_nw;
        check32($sformatf("rnd%0d_mem", i), mem[idx], ref_mem[idx]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
